// File: rtl/frame_collector.sv
// frame_collector: gathers a serial stream of signed samples into a parallel frame of NUM_INPUTS elements.
// Latency: the frame is visible (out_valid=1) one edge after its last sample is accepted; full throughput when out_ready=1.
// Backpressure: while a frame waits with out_ready=0, in_ready=0 and all outputs hold. Optional macro: FRAME_COLLECTOR_FLUSH_EN.
module frame_collector #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  localparam int CNT_W     = $clog2(NUM_INPUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data [NUM_INPUTS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        fill_level
`ifdef FRAME_COLLECTOR_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(NUM_INPUTS - 1);
  // Padding for flushed frames: cannot win a downstream max.
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] data_q [NUM_INPUTS];
  logic signed [WIDTH-1:0] data_d [NUM_INPUTS];
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic                    flush_go;
  logic                    samp_acc;
  logic                    frame_acc;

`ifdef FRAME_COLLECTOR_FLUSH_EN
  // A flush only takes effect on an idle output with a non-empty partial frame.
  assign flush_go = flush && !valid_q && (fill_q != '0);
`else
  assign flush_go = 1'b0;
`endif

  // Ready depends only on reset, held frame, consumer and flush -- never on in_valid.
  assign in_ready  = !rst && (!valid_q || out_ready) && !flush_go;
  assign samp_acc  = in_valid && in_ready;
  assign frame_acc = valid_q && out_ready;

  // Next-state: frame hand-off, sample write / frame completion, optional flush padding.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fill_d  = fill_q;

    if (frame_acc) begin
      valid_d = 1'b0;
    end

    if (samp_acc) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (CNT_W'(i) == fill_q) begin
          data_d[i] = in_data;
        end
      end
      if (fill_q == LAST_IDX) begin
        fill_d  = '0;
        valid_d = 1'b1;
      end else begin
        fill_d = fill_q + CNT_W'(1);
      end
    end

    if (flush_go) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (CNT_W'(i) >= fill_q) begin
          data_d[i] = MOST_NEG;
        end
      end
      fill_d  = '0;
      valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset drops any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_frame_collector.sv
// Bench for frame_collector: table-driven vectors, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_frame_collector;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] out_data [N];
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        fill_level;
  logic              flush_s;

  logic signed [7:0] i1_data;
  logic              i1_valid;
  logic              i1_ready;
  logic signed [7:0] o1_data [1];
  logic              o1_valid;
  logic              o1_ready;
  logic [0:0]        fill1;

  frame_collector #(.WIDTH(8), .NUM_INPUTS(N)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level)
`ifdef FRAME_COLLECTOR_FLUSH_EN
    , .flush(flush_s)
`endif
  );

  frame_collector #(.WIDTH(8), .NUM_INPUTS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(i1_data), .in_valid(i1_valid), .in_ready(i1_ready),
    .out_data(o1_data), .out_valid(o1_valid), .out_ready(o1_ready), .fill_level(fill1)
`ifdef FRAME_COLLECTOR_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: accepted samples queue up until N form a frame.
  int m_cur[$];
  int m_frame[N];
  bit m_pend;

  task automatic cycle(input bit iv, input int d, input bit ordy, input bit r, input bit fl);
    bit exp_rdy, fgo, sa, fa;
    @(negedge clk);
    in_valid  = iv;
    in_data   = 8'(d);
    out_ready = ordy;
    rst       = r;
    flush_s   = fl;
    #1;
`ifdef FRAME_COLLECTOR_FLUSH_EN
    fgo = fl && !m_pend && (m_cur.size() > 0);
`else
    fgo = 1'b0;
`endif
    exp_rdy = !r && (!m_pend || ordy) && !fgo;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_cur.delete();
      m_pend = 1'b0;
    end else begin
      fa = m_pend && ordy;
      sa = iv && exp_rdy;
      if (fa) m_pend = 1'b0;
      if (fgo) begin
        while (m_cur.size() < N) m_cur.push_back(-128);
      end
      if (sa) m_cur.push_back(8'(d) > 127 ? int'(8'(d)) - 256 : int'(8'(d)));
      if (m_cur.size() == N) begin
        for (int i = 0; i < N; i++) m_frame[i] = m_cur[i];
        m_cur.delete();
        m_pend = 1'b1;
      end
    end
    #1;
    chk("out_valid", int'(out_valid), int'(m_pend));
    chk("fill_level", int'(fill_level), m_cur.size());
    if (m_pend) begin
      for (int i = 0; i < N; i++) chk($sformatf("out_data[%0d]", i), int'(out_data[i]), m_frame[i]);
    end
  endtask

  task automatic chk_frame(input string name, input int e0, input int e1, input int e2, input int e3);
    int e[N];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), int'(out_data[i]), e[i]);
  endtask

  typedef struct {
    bit iv;
    int d;
    bit ordy;
    bit e_vld;
    int e_fill;
  } vec_t;

  vec_t tbl[5];
  int   b2b[8];

  initial begin
    tbl[0] = '{1'b1,   3, 1'b1, 1'b0, 1};
    tbl[1] = '{1'b1,  -7, 1'b1, 1'b0, 2};
    tbl[2] = '{1'b1,  12, 1'b1, 1'b0, 3};
    tbl[3] = '{1'b1,   5, 1'b1, 1'b1, 0};
    tbl[4] = '{1'b0,   0, 1'b1, 1'b0, 0};
    b2b    = '{1, 2, 3, 4, -1, -2, -3, -4};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_s = 1'b0;
    i1_valid = 1'b0; i1_data = '0; o1_ready = 1'b0;
    m_pend = 1'b0;

    // Reset state
    cycle(1'b1, 9, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_frame("reset_data", 0, 0, 0, 0);

    // Single frame, table-driven
    for (int k = 0; k < 5; k++) begin
      cycle(tbl[k].iv, tbl[k].d, tbl[k].ordy, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", k), int'(out_valid), int'(tbl[k].e_vld));
      chk($sformatf("tbl%0d_fill", k), int'(fill_level), tbl[k].e_fill);
      if (k == 3) chk_frame("frame1", 3, -7, 12, 5);
    end

    // Back-to-back frames, continuous valid and ready
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, b2b[k], 1'b1, 1'b0, 1'b0);
      chk($sformatf("b2b%0d_valid", k), int'(out_valid), (k == 3 || k == 7) ? 1 : 0);
      if (k == 3) chk_frame("b2b_f1", 1, 2, 3, 4);
      if (k == 7) chk_frame("b2b_f2", -1, -2, -3, -4);
    end
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Backpressure: frame held while out_ready=0
    cycle(1'b1, 10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 30, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 40, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 77, 1'b0, 1'b0, 1'b0);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    chk_frame("held", 10, 20, 30, 40);
    cycle(1'b1, 99, 1'b1, 1'b0, 1'b0);
    chk("release_valid", int'(out_valid), 0);
    chk("release_fill", int'(fill_level), 1);
    chk("release_elem0", int'(out_data[0]), 99);

    // Reset mid-frame, then a clean frame
    cycle(1'b1, 55, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_fill", int'(fill_level), 2);
    cycle(1'b1, 66, 1'b1, 1'b1, 1'b0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_fill", int'(fill_level), 0);
    chk_frame("rst_data", 0, 0, 0, 0);
    cycle(1'b1,    8, 1'b1, 1'b0, 1'b0);
    cycle(1'b1,    8, 1'b1, 1'b0, 1'b0);
    cycle(1'b1,    8, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, -128, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", int'(out_valid), 1);
    chk_frame("post_rst", 8, 8, 8, -128);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // NUM_INPUTS=1: every sample is a frame
    @(negedge clk);
    i1_valid = 1'b1; i1_data = -8'sd128; o1_ready = 1'b1;
    #1 chk("n1_ready0", int'(i1_ready), 1);
    @(posedge clk); #1;
    chk("n1_valid0", int'(o1_valid), 1);
    chk("n1_data0", int'(o1_data[0]), -128);
    chk("n1_fill0", int'(fill1), 0);
    @(negedge clk);
    i1_data = 8'sd127;
    #1 chk("n1_ready1", int'(i1_ready), 1);
    @(posedge clk); #1;
    chk("n1_valid1", int'(o1_valid), 1);
    chk("n1_data1", int'(o1_data[0]), 127);
    chk("n1_fill1", int'(fill1), 0);
    @(negedge clk);
    i1_valid = 1'b0;

`ifdef FRAME_COLLECTOR_FLUSH_EN
    // Flush a partial frame
    cycle(1'b1,  6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, -2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 33, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", int'(out_valid), 1);
    chk("flush_fill", int'(fill_level), 0);
    chk_frame("flush", 6, -2, -128, -128);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0, int'($urandom % 256) - 128, ($urandom % 3) != 0,
            ($urandom % 64) == 0, ($urandom % 8) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
